regfile_ctx_seq: RTL
====================

Name: regfile_ctx_seq

Overview:
- Context save/restore sequencer and write-port owner for the 16x16 register file. Sits between core writeback and the register file write port.
- On save, walks every register through one read port and streams the words out over a valid/ready interface.
- On restore, accepts a valid/ready stream and writes it back register by register.
- When idle, passes core writeback straight through to the register file.

Parameters:
- DataWidth, 16, register width in bits.
- NumRegs, 16, number of registers sequenced.
- IndexWidth, $clog2(NumRegs), register index width.

Ports:
- clk  in  1  clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- saveReq  in  1  start save; sampled only in IDLE.
- restoreReq  in  1  start restore; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE; the core stalls on it.
- done  out  1  one-cycle pulse when a save or restore completes.
- coreWriteEn  in  1  core writeback enable.
- coreWriteAddr  in  IndexWidth  core writeback index.
- coreWriteData  in  DataWidth  core writeback data.
- rfReadAddr  out  IndexWidth  drives one register file read port.
- rfReadData  in  DataWidth  combinational read data for rfReadAddr.
- rfWriteEn  out  1  register file write enable.
- rfWriteAddr  out  IndexWidth  register file write index.
- rfWriteData  out  DataWidth  register file write data.
- outValid  out  1  save stream word valid.
- outReady  in  1  save stream consumer ready.
- outData  out  DataWidth  save stream word.
- inValid  in  1  restore stream word valid.
- inReady  out  1  restore stream accept.
- inData  in  DataWidth  restore stream word.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rstN). Reset is asserted asynchronously and released synchronously to clk by the system.
- Reset values: state=IDLE, idx=0, busy=0, done=0, outValid=0, outData=0, inReady=0.
- States: IDLE, SAVE, SAVE_DRAIN, RESTORE, DONE.
- IDLE:
  - rfWriteEn/Addr/Data = coreWriteEn/Addr/Data, combinational pass-through.
  - rfReadAddr = idx.
  - saveReq -> SAVE with idx=first index.
  - Otherwise restoreReq -> RESTORE with idx=first index.
  - Both requests high in the same cycle: save wins; restoreReq is ignored and not queued.
- First index is 0; last index is NumRegs-1.
- SAVE:
  - rfReadAddr=idx.
  - Single-entry output register (outValid/outData).
  - Load rule: when outValid=0 or (outValid && outReady), load outData<=rfReadData, set outValid<=1, idx<=idx+1.
  - When the loaded idx is the last index -> SAVE_DRAIN.
  - One word per cycle under continuous outReady.
- SAVE_DRAIN: hold outData until outValid && outReady, then outValid<=0 -> DONE.
- RESTORE:
  - inReady=1 combinationally.
  - On inValid: rfWriteEn=1, rfWriteAddr=idx, rfWriteData=inData, idx<=idx+1.
  - Write of the last index -> DONE.
  - inValid low: no write, idx holds.
- DONE: done=1 for exactly one cycle, idx<=0 -> IDLE. busy is still high in DONE.
- Core writes while busy=1 are dropped: never forwarded, never queued.
- rfWriteEn=0 in SAVE, SAVE_DRAIN and DONE.
- saveReq/restoreReq while busy are ignored.
- idx never wraps past the last index; the terminal compare uses the last index, not overflow.
- outValid, once high, stays high with outData stable until accepted.
- rstN low in any state: immediate return to reset values. A partially transferred context is abandoned; no done pulse.
- outReady asserted in IDLE/RESTORE has no effect.
- inValid asserted outside RESTORE is not accepted (inReady=0).

Optional Feature:
- Macro REGCTX_SKIP_R0_EN.
- Defined:
  - Register 0 is treated as hardwired zero; first index=1.
  - Save emits NumRegs-1 words (r1..r15) and restore consumes NumRegs-1 words.
  - Core writes with coreWriteAddr=0 are dropped even in IDLE.
- Undefined:
  - First index=0; NumRegs words per transfer.
  - All core writes pass through in IDLE.

Test Plan:
- Pass-through: IDLE, coreWriteEn=1, coreWriteAddr=5, coreWriteData=0xBEEF -> same-cycle rfWriteEn=1, rfWriteAddr=5, rfWriteData=0xBEEF; busy=0.
- Save: preload rN=0x1000+N, pulse saveReq, outReady=1 -> 16 consecutive words 0x1000..0x100F (15 words 0x1001..0x100F with the macro), then done pulse, then busy=0.
- Backpressure: save with outReady toggling 1,0,0,1 -> outData held stable while outValid && !outReady; no word lost or duplicated; word order preserved.
- Restore: pulse restoreReq, stream 0xA000+N with inValid low every third cycle -> register N = 0xA000+N after done; rfWriteEn asserted only on inValid cycles.
- Contention: saveReq and restoreReq together -> save runs. Core write to r3 during SAVE -> r3 unchanged, and its saved word equals the pre-save value.
- Reset mid-save: rstN low after 7 words -> outValid=0, busy=0 immediately, no done pulse. A new saveReq after release restarts from the first index.

Source files
------------

// File: rtl/regfile_ctx_seq_if.sv
// Save/restore stream bundle between the context sequencer and its peer.
// Both directions transfer a word on a rising clk edge where valid && ready are both high.
// A producer holds valid and data stable until that edge, and never waits on ready to raise valid.
interface regfile_ctx_seq_if #(
    parameter int DataWidth = 16
) ();
    logic                 outValid;
    logic                 outReady;
    logic [DataWidth-1:0] outData;
    logic                 inValid;
    logic                 inReady;
    logic [DataWidth-1:0] inData;

    modport master (
        output outValid, outData, inReady,
        input  outReady, inValid, inData
    );

    modport slave (
        input  outValid, outData, inReady,
        output outReady, inValid, inData
    );
endinterface

// File: rtl/regfile_ctx_seq.sv
// Context save/restore sequencer and register file write-port owner.
// Optional macro REGCTX_SKIP_R0_EN: r0 is hardwired zero and is skipped by save/restore and core writes.
module regfile_ctx_seq #(
    parameter int DataWidth  = 16,
    parameter int NumRegs    = 16,
    parameter int IndexWidth = $clog2(NumRegs)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  saveReq,
    input  logic                  restoreReq,
    output logic                  busy,
    output logic                  done,
    input  logic                  coreWriteEn,
    input  logic [IndexWidth-1:0] coreWriteAddr,
    input  logic [DataWidth-1:0]  coreWriteData,
    output logic [IndexWidth-1:0] rfReadAddr,
    input  logic [DataWidth-1:0]  rfReadData,
    output logic                  rfWriteEn,
    output logic [IndexWidth-1:0] rfWriteAddr,
    output logic [DataWidth-1:0]  rfWriteData,
    regfile_ctx_seq_if.master     strm,
    output logic [2:0]            dbgState
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SAVE       = 3'd1,
        S_SAVE_DRAIN = 3'd2,
        S_RESTORE    = 3'd3,
        S_DONE       = 3'd4
    } state_t;

`ifdef REGCTX_SKIP_R0_EN
    localparam logic [IndexWidth-1:0] FirstIdx = IndexWidth'(1);
`else
    localparam logic [IndexWidth-1:0] FirstIdx = '0;
`endif
    localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);

    state_t                state_q, state_d;
    logic [IndexWidth-1:0] idx_q, idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [DataWidth-1:0]  out_data_q, out_data_d;
    logic                  core_wr_ok;

`ifdef REGCTX_SKIP_R0_EN
    assign core_wr_ok = coreWriteEn && (coreWriteAddr != '0);
`else
    assign core_wr_ok = coreWriteEn;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        rfReadAddr   = idx_q;
        rfWriteEn    = 1'b0;
        rfWriteAddr  = coreWriteAddr;
        rfWriteData  = coreWriteData;
        strm.inReady = 1'b0;
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                rfWriteEn = core_wr_ok;
                if (saveReq) begin
                    state_d = S_SAVE;
                    idx_d   = FirstIdx;
                end else if (restoreReq) begin
                    state_d = S_RESTORE;
                    idx_d   = FirstIdx;
                end
            end
            S_SAVE: begin
                // Output register refills whenever it is empty or being drained this cycle.
                if (!out_valid_q || strm.outReady) begin
                    out_data_d  = rfReadData;
                    out_valid_d = 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = S_SAVE_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_SAVE_DRAIN: begin
                if (strm.outReady) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_RESTORE: begin
                strm.inReady = 1'b1;
                rfWriteAddr  = idx_q;
                rfWriteData  = strm.inData;
                if (strm.inValid) begin
                    rfWriteEn = 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign strm.outValid = out_valid_q;
    assign strm.outData  = out_data_q;
    assign dbgState      = state_q;

endmodule
